// File: rtl/cache_line_store.sv
// Fully-associative line store with per-line age ranking.
// Supplies hit/valid/data, free and LRU victim info to the cache controller.
module cache_line_store #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int LINES  = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_i,
  input  logic                       we_i,
  input  logic [ADDR_W-1:0]          adr_i,
  input  logic [DATA_W-1:0]          dat_i,
  output logic                       hit_o,
  output logic                       valid_o,
  output logic [DATA_W-1:0]          dat_o,
  output logic                       free_o,
  output logic [ADDR_W-1:0]          lru_adr_o,
  output logic [DATA_W-1:0]          lru_dat_o,
  output logic [$clog2(LINES+1)-1:0] count_o
);

  localparam int IW = $clog2(LINES);
  localparam int CW = $clog2(LINES+1);
  localparam logic [IW-1:0] AGE_MAX = IW'(LINES-1);
  localparam logic [CW-1:0] CNT_MAX = CW'(LINES);

  logic [ADDR_W-1:0] tag_q [LINES];
  logic [ADDR_W-1:0] tag_d [LINES];
  logic [DATA_W-1:0] dat_q [LINES];
  logic [DATA_W-1:0] dat_d [LINES];
  logic [IW-1:0]     age_q [LINES];
  logic [IW-1:0]     age_d [LINES];
  logic [LINES-1:0]  vld_q;
  logic [LINES-1:0]  vld_d;
  logic [CW-1:0]     cnt_q;
  logic [CW-1:0]     cnt_d;

  logic [LINES-1:0]  vmatch;
  logic [LINES-1:0]  imatch;
  logic              vhit;
  logic              ihit;
  logic [IW-1:0]     vidx;
  logic [IW-1:0]     iidx;
  logic [IW-1:0]     fidx;
  logic [IW-1:0]     lidx;
  logic [IW-1:0]     widx;
  logic [IW-1:0]     k;
  logic [IW-1:0]     a;
  logic              free;
  logic              wr;
  logic              upd;

  always_comb begin
    vmatch = '0;
    imatch = '0;
    vhit   = 1'b0;
    ihit   = 1'b0;
    vidx   = '0;
    iidx   = '0;
    fidx   = '0;
    lidx   = '0;
    for (int i = 0; i < LINES; i++) begin
      vmatch[i] = vld_q[i] && (tag_q[i] == adr_i);
      imatch[i] = !vld_q[i] && (tag_q[i] == adr_i);
    end
    // Scan downward so the lowest index wins.
    for (int i = LINES-1; i >= 0; i--) begin
      if (vmatch[i]) begin
        vhit = 1'b1;
        vidx = IW'(i);
      end
      if (imatch[i]) begin
        ihit = 1'b1;
        iidx = IW'(i);
      end
      if (!vld_q[i]) fidx = IW'(i);
      if (age_q[i] == AGE_MAX) lidx = IW'(i);
    end
  end

  assign free = (cnt_q != CNT_MAX);
  assign widx = vhit ? vidx : iidx;

  assign hit_o     = vhit | ihit;
  assign valid_o   = hit_o ? vld_q[widx] : 1'b0;
  assign dat_o     = hit_o ? dat_q[widx] : '0;
  assign free_o    = free;
  assign lru_adr_o = tag_q[lidx];
  assign lru_dat_o = dat_q[lidx];
  assign count_o   = cnt_q;

  assign wr  = req_i & we_i;
  assign upd = req_i & (vhit | we_i);

  always_comb begin
    if (vhit)      k = vidx;
    else if (free) k = fidx;
    else           k = lidx;
  end

  assign a = age_q[k];

  always_comb begin
    vld_d = vld_q;
    cnt_d = cnt_q;
    for (int i = 0; i < LINES; i++) begin
      tag_d[i] = tag_q[i];
      dat_d[i] = dat_q[i];
      age_d[i] = age_q[i];
    end
    if (wr) begin
      tag_d[k] = adr_i;
      dat_d[k] = dat_i;
      vld_d[k] = 1'b1;
      if (!vhit && free) cnt_d = cnt_q + CW'(1);
    end
    // Promote line k to MRU; younger lines age by one.
    if (upd) begin
      for (int i = 0; i < LINES; i++) begin
        if (age_q[i] < a) age_d[i] = age_q[i] + IW'(1);
      end
      age_d[k] = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= '0;
        dat_q[i] <= '0;
        age_q[i] <= IW'(i);
      end
    end else begin
      vld_q <= vld_d;
      cnt_q <= cnt_d;
      for (int i = 0; i < LINES; i++) begin
        tag_q[i] <= tag_d[i];
        dat_q[i] <= dat_d[i];
        age_q[i] <= age_d[i];
      end
    end
  end

endmodule

// File: tb/tb_cache_line_store.sv
// Directed bench for cache_line_store.
// Hand-computed expectations for allocate, hit, evict and reset paths.
module tb_cache_line_store;

  logic       clk;
  logic       rst;
  logic       req_i;
  logic       we_i;
  logic [7:0] adr_i;
  logic [7:0] dat_i;
  logic       hit_o;
  logic       valid_o;
  logic [7:0] dat_o;
  logic       free_o;
  logic [7:0] lru_adr_o;
  logic [7:0] lru_dat_o;
  logic [2:0] count_o;

  int tests = 0;
  int fails = 0;

  cache_line_store #(
    .ADDR_W(8),
    .DATA_W(8),
    .LINES (4)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .req_i    (req_i),
    .we_i     (we_i),
    .adr_i    (adr_i),
    .dat_i    (dat_i),
    .hit_o    (hit_o),
    .valid_o  (valid_o),
    .dat_o    (dat_o),
    .free_o   (free_o),
    .lru_adr_o(lru_adr_o),
    .lru_dat_o(lru_dat_o),
    .count_o  (count_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [15:0] obs,
                     input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic r, input logic w,
                       input logic [7:0] ad, input logic [7:0] d);
    req_i = r;
    we_i  = w;
    adr_i = ad;
    dat_i = d;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'h00, 8'h00);
    tick();
    tick();
    rst = 1'b0;

    // reset state
    drive(0, 0, 8'h00, 8'h00);
    chk("rst_hit0", 16'(hit_o), 16'h1);
    chk("rst_vld0", 16'(valid_o), 16'h0);
    chk("rst_free", 16'(free_o), 16'h1);
    chk("rst_cnt", 16'(count_o), 16'h0);
    chk("rst_lru_adr", 16'(lru_adr_o), 16'h00);
    chk("rst_lru_dat", 16'(lru_dat_o), 16'h00);

    // T1 read miss
    drive(1, 0, 8'h10, 8'h00);
    chk("t1_hit", 16'(hit_o), 16'h0);
    chk("t1_free", 16'(free_o), 16'h1);
    chk("t1_cnt", 16'(count_o), 16'h0);
    tick();
    chk("t1_cnt_after", 16'(count_o), 16'h0);
    chk("t1_hit_after", 16'(hit_o), 16'h0);

    // T2 two allocations then a read hit
    drive(1, 1, 8'h10, 8'hAA);
    chk("t2_wr_dat_old", 16'(dat_o), 16'h00);
    tick();
    drive(1, 1, 8'h20, 8'hBB);
    tick();
    drive(1, 0, 8'h10, 8'h00);
    chk("t2_hit", 16'(hit_o), 16'h1);
    chk("t2_vld", 16'(valid_o), 16'h1);
    chk("t2_dat", 16'(dat_o), 16'hAA);
    chk("t2_cnt", 16'(count_o), 16'h2);
    tick();

    // T3 fill all four lines
    drive(1, 1, 8'h10, 8'hAA);
    tick();
    drive(1, 1, 8'h20, 8'hBB);
    tick();
    drive(1, 1, 8'h30, 8'h33);
    tick();
    drive(1, 1, 8'h40, 8'h44);
    tick();
    drive(0, 0, 8'h00, 8'h00);
    chk("t3_free", 16'(free_o), 16'h0);
    chk("t3_cnt", 16'(count_o), 16'h4);
    chk("t3_lru_adr", 16'(lru_adr_o), 16'h10);
    chk("t3_lru_dat", 16'(lru_dat_o), 16'hAA);
    drive(1, 0, 8'h10, 8'h00);
    chk("t3_rd_dat", 16'(dat_o), 16'hAA);
    tick();
    chk("t3_lru_adr2", 16'(lru_adr_o), 16'h20);
    chk("t3_lru_dat2", 16'(lru_dat_o), 16'hBB);

    // T4 eviction of 0x20
    drive(1, 1, 8'h50, 8'h55);
    chk("t4_miss", 16'(hit_o), 16'h0);
    tick();
    drive(1, 0, 8'h20, 8'h00);
    chk("t4_evicted", 16'(hit_o), 16'h0);
    chk("t4_evicted_dat", 16'(dat_o), 16'h00);
    tick();
    drive(0, 0, 8'h50, 8'h00);
    chk("t4_new_hit", 16'({hit_o, valid_o}), 16'h3);
    chk("t4_new_dat", 16'(dat_o), 16'h55);
    chk("t4_lru_adr", 16'(lru_adr_o), 16'h30);
    chk("t4_cnt", 16'(count_o), 16'h4);

    // T5 write hit, no eviction
    drive(1, 1, 8'h30, 8'hCC);
    chk("t5_old_dat", 16'(dat_o), 16'h33);
    tick();
    drive(0, 0, 8'h30, 8'h00);
    chk("t5_dat", 16'(dat_o), 16'hCC);
    chk("t5_cnt", 16'(count_o), 16'h4);
    chk("t5_lru_adr", 16'(lru_adr_o), 16'h40);
    chk("t5_lru_dat", 16'(lru_dat_o), 16'h44);
    drive(0, 0, 8'h10, 8'h00);
    chk("t5_keep_10", 16'(dat_o), 16'hAA);

    // write without req is ignored
    drive(0, 1, 8'h70, 8'h77);
    tick();
    drive(0, 0, 8'h70, 8'h00);
    chk("noreq_hit", 16'(hit_o), 16'h0);
    chk("noreq_lru", 16'(lru_adr_o), 16'h40);

    // T6 reset beats a write in the same cycle
    rst = 1'b1;
    drive(1, 1, 8'h60, 8'h66);
    tick();
    rst = 1'b0;
    drive(0, 0, 8'h60, 8'h00);
    chk("t6_hit", 16'(hit_o), 16'h0);
    chk("t6_cnt", 16'(count_o), 16'h0);
    chk("t6_free", 16'(free_o), 16'h1);
    chk("t6_lru_adr", 16'(lru_adr_o), 16'h00);
    drive(0, 0, 8'h00, 8'h00);
    chk("t6_hit0", 16'({hit_o, valid_o}), 16'h2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
